uart_tx_queue: RTL and testbench

Byte queue between the ROM-driven CPU and the `buart` transmitter. The CPU pushes output bytes without waiting on the UART. The queue drains them into `buart` using its `wr`/`busy` handshake. This removes the CPU's UART wait states and makes back-to-back SEND instructions cheap.

---
 rtl/uart_txq_pkg.sv | 13 +
 rtl/uart_tx_queue_if.sv | 28 ++
 rtl/txq_fifo.sv | 85 ++++++++
 rtl/uart_tx_queue.sv | 106 ++++++++++
 tb/tb_uart_tx_queue.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_txq_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_txq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GUARD  = 2'd2
  } drain_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus between the CPU/UART side and the transmit queue.
// slave: the queue itself; master: whoever drives push and busy.
interface uart_tx_queue_if #(
  parameter int DEPTH_LOG2 = 4
);

  logic                  push;
  logic [7:0]            push_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  clr_overflow;
  logic                  uart_busy;
  logic                  uart_wr;
  logic [7:0]            uart_data;

  modport slave (
    input  push, push_data, clr_overflow, uart_busy,
    output full, empty, level, overflow, uart_wr, uart_data
  );

  modport master (
    output push, push_data, clr_overflow, uart_busy,
    input  full, empty, level, overflow, uart_wr, uart_data
  );

endinterface

// File: rtl/txq_fifo.sv
// Byte FIFO: storage, wrapping pointers, level counter, registered
// full/empty flags and sticky overflow on dropped pushes.
module txq_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [7:0]          push_data_i,
  input  logic                pop_i,
  input  logic                clr_overflow_i,
  output logic [7:0]          head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic                overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  push_ok, pop_ok, drop;

  // Accept/drop decisions use the registered full flag only.
  assign push_ok = push_i && !full_q;
  assign drop    = push_i && full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Next-state for pointers, level, flags and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == (DEPTH_LOG2+1)'(DEPTH));
    empty_d = (level_d == '0);
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)                overflow_d = 1'b1;
    else if (clr_overflow_i) overflow_d = 1'b0;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are meaningless once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue between CPU and buart: buffers pushed bytes and drains
// them with a wr/busy handshake (IDLE -> STROBE -> GUARD -> IDLE).
// Optional build macro UART_TXQ_CRLF_EN inserts a CR before every LF.
module uart_tx_queue
  import uart_txq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_queue_if.slave    bus
);

  drain_state_e state_q, state_d;
  logic         uart_wr_q, uart_wr_d;
  logic [7:0]   uart_data_q, uart_data_d;
  logic         pop;
  logic [7:0]   head;
  logic         empty;
  logic         service;
`ifdef UART_TXQ_CRLF_EN
  logic         cr_pend_q, cr_pend_d;
`endif

  txq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (bus.push),
    .push_data_i    (bus.push_data),
    .pop_i          (pop),
    .clr_overflow_i (bus.clr_overflow),
    .head_o         (head),
    .full_o         (bus.full),
    .empty_o        (empty),
    .level_o        (bus.level),
    .overflow_o     (bus.overflow)
  );

  assign bus.empty = empty;

  // busy is only looked at while idle.
  assign service = (state_q == IDLE) && !empty && !bus.uart_busy;

  // State and registered UART outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      uart_wr_q   <= 1'b0;
      uart_data_q <= 8'h00;
`ifdef UART_TXQ_CRLF_EN
      cr_pend_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      uart_wr_q   <= uart_wr_d;
      uart_data_q <= uart_data_d;
`ifdef UART_TXQ_CRLF_EN
      cr_pend_q   <= cr_pend_d;
`endif
    end
  end

  // Next-state: one strobe cycle, one guard cycle for buart to raise busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (service) state_d = STROBE;
      STROBE:  state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: load the byte and pop on service; wr drops after one cycle.
  always_comb begin
    uart_wr_d   = 1'b0;
    uart_data_d = uart_data_q;
    pop         = 1'b0;
`ifdef UART_TXQ_CRLF_EN
    cr_pend_d   = cr_pend_q;
`endif
    if (service) begin
      uart_wr_d = 1'b1;
`ifdef UART_TXQ_CRLF_EN
      // LF at the head goes out as CR first, then LF on the next service.
      if (head == ASCII_LF && !cr_pend_q) begin
        uart_data_d = ASCII_CR;
        cr_pend_d   = 1'b1;
      end else begin
        uart_data_d = head;
        pop         = 1'b1;
        cr_pend_d   = 1'b0;
      end
`else
      uart_data_d = head;
      pop         = 1'b1;
`endif
    end
  end

  assign bus.uart_wr   = uart_wr_q;
  assign bus.uart_data = uart_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: drain timing, overflow, CRLF, wrap, reset.
module tb_uart_tx_queue;

  localparam int DL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] cap [$];
  int         cap_t [$];

  // Record every strobe with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.uart_wr === 1'b1) begin
      cap.push_back(bus.uart_data);
      cap_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] capv(input int i);
    if (i < cap.size()) return cap[i];
    return 8'hxx;
  endfunction

  function automatic int capt(input int i);
    if (i < cap_t.size()) return cap_t[i];
    return -1000;
  endfunction

  initial begin
    bus.push         = 1'b0;
    bus.push_data    = 8'h00;
    bus.clr_overflow = 1'b0;
    bus.uart_busy    = 1'b0;
    reset            = 1'b1;
    tick(3);
    chk("rst_wr",    bus.uart_wr,   0);
    chk("rst_data",  bus.uart_data, 0);
    chk("rst_level", bus.level,     0);
    chk("rst_empty", bus.empty,     1);
    chk("rst_full",  bus.full,      0);
    chk("rst_ovf",   bus.overflow,  0);
    reset = 1'b0;
    tick(2);

    // Three bytes, idle UART.
    cap.delete(); cap_t.delete();
    bus.push = 1'b1; bus.push_data = 8'h41;
    tick();
    chk("t1_empty0", bus.empty, 0);
    chk("t1_lvl1",   bus.level, 1);
    chk("t1_wr0",    bus.uart_wr, 0);
    bus.push_data = 8'h42;
    tick();
    chk("t1_wr1",    bus.uart_wr, 1);
    chk("t1_data41", bus.uart_data, 8'h41);
    chk("t1_lvlpp",  bus.level, 1);
    bus.push_data = 8'h43;
    tick();
    bus.push = 1'b0;
    chk("t1_wrpulse", bus.uart_wr, 0);
    chk("t1_data_hold", bus.uart_data, 8'h41);
    chk("t1_lvl2",   bus.level, 2);
    tick(12);
    chk("t1_count",  cap.size(), 3);
    chk("t1_b0", capv(0), 8'h41);
    chk("t1_b1", capv(1), 8'h42);
    chk("t1_b2", capv(2), 8'h43);
    chk("t1_gap01", capt(1) - capt(0), 3);
    chk("t1_gap12", capt(2) - capt(1), 3);
    chk("t1_empty", bus.empty, 1);

    // Fill while busy; 17th push dropped.
    bus.uart_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.push = 1'b1; bus.push_data = 8'(i);
      tick();
      if (i == 15) begin
        chk("t2_full16",  bus.full, 1);
        chk("t2_level16", bus.level, 16);
        chk("t2_noovf",   bus.overflow, 0);
      end
    end
    bus.push = 1'b0;
    chk("t2_ovf",    bus.overflow, 1);
    chk("t2_lvl",    bus.level, 16);
    chk("t2_wr_busy", bus.uart_wr, 0);

    // Clear collides with a drop: drop wins.
    bus.push = 1'b1; bus.push_data = 8'h77; bus.clr_overflow = 1'b1;
    tick();
    bus.push = 1'b0; bus.clr_overflow = 1'b0;
    chk("t3_ovf_kept", bus.overflow, 1);
    chk("t3_lvl",      bus.level, 16);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("t3_ovf_clr",  bus.overflow, 0);

    // Drain the full queue.
    cap.delete(); cap_t.delete();
    bus.uart_busy = 1'b0;
    tick(16 * 3 + 6);
    chk("t2_count", cap.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t2_b%0d", i), capv(i), 8'(i));
    chk("t2_empty", bus.empty, 1);

    // LF handling.
    bus.uart_busy = 1'b1;
    bus.push = 1'b1; bus.push_data = 8'h48;
    tick();
    bus.push_data = 8'h0A;
    tick();
    bus.push = 1'b0;
    chk("t4_lvl2", bus.level, 2);
    cap.delete(); cap_t.delete();
    bus.uart_busy = 1'b0;
    tick();
    chk("t4_lvl_a", bus.level, 1);
    tick(3);
`ifdef UART_TXQ_CRLF_EN
    chk("t4_lvl_b", bus.level, 1);
`else
    chk("t4_lvl_b", bus.level, 0);
`endif
    tick(3);
    chk("t4_lvl_c", bus.level, 0);
    tick(6);
`ifdef UART_TXQ_CRLF_EN
    chk("t4_count", cap.size(), 3);
    chk("t4_b0", capv(0), 8'h48);
    chk("t4_b1", capv(1), 8'h0D);
    chk("t4_b2", capv(2), 8'h0A);
`else
    chk("t4_count", cap.size(), 2);
    chk("t4_b0", capv(0), 8'h48);
    chk("t4_b1", capv(1), 8'h0A);
`endif

    // Steady pushes with toggling busy; pointers wrap.
    cap.delete(); cap_t.delete();
    for (int i = 0; i < 20; i++) begin
      bus.uart_busy = (i % 2 == 1);
      bus.push = 1'b1; bus.push_data = 8'(8'h60 + i);
      tick();
      bus.push = 1'b0;
      tick(2);
    end
    bus.uart_busy = 1'b0;
    tick(60);
    chk("t5_count", cap.size(), 20);
    for (int i = 0; i < 20; i++) chk($sformatf("t5_b%0d", i), capv(i), 8'(8'h60 + i));
    chk("t5_ovf",   bus.overflow, 0);
    chk("t5_empty", bus.empty, 1);

    // Reset while strobing with 5 bytes still queued.
    bus.uart_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.push = 1'b1; bus.push_data = 8'(8'hA0 + i);
      tick();
    end
    bus.push = 1'b0;
    chk("t6_lvl6", bus.level, 6);
    bus.uart_busy = 1'b0;
    tick();
    chk("t6_wr1",  bus.uart_wr, 1);
    chk("t6_lvl5", bus.level, 5);
    reset = 1'b1;
    tick();
    chk("t6_wr0",    bus.uart_wr, 0);
    chk("t6_lvl0",   bus.level, 0);
    chk("t6_empty",  bus.empty, 1);
    chk("t6_data0",  bus.uart_data, 0);
    reset = 1'b0;
    cap.delete(); cap_t.delete();
    tick(20);
    chk("t6_nostrobe", cap.size(), 0);
    chk("t6_empty2",   bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
